// File: rtl/typing_game_ctrl.sv
// Reaction-time typing game controller: shows a random letter, times the player's keypress.
// Optional best-time tracking is enabled by defining TGC_BEST_TIME_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, waiting for a release code to start a game
// WAIT_REL | between rounds, waiting for the held key to be released
// PLAY     | goal letter shown, reaction counter running
// LOSS     | game over, too many misses; outputs frozen
// DONE     | game over, all rounds played; outputs frozen
module typing_game_ctrl #(
    parameter int CODE_W       = 5,
    parameter int RELEASE_CODE = 21,
    parameter int ROUNDS       = 8,
    parameter int MAX_MISS     = 3,
    parameter int TIMEOUT      = 100000000,
    parameter int CNT_W        = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [CODE_W-1:0] key_code,
    input  logic [CODE_W-1:0] rand_code,
    output logic [2:0]        state,
    output logic [CODE_W-1:0] goal_code,
    output logic [7:0]        score,
    output logic [7:0]        misses,
    output logic [7:0]        round_idx,
    output logic [CNT_W-1:0]  react_time,
    output logic              win,
    output logic              loss
`ifdef TGC_BEST_TIME_EN
    ,
    output logic [CNT_W-1:0]  best_time
`endif
);

    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

    if (longint'(TIMEOUT) > MAX_CNT) begin : g_timeout_too_big
        $error("typing_game_ctrl: TIMEOUT does not fit in CNT_W bits");
    end

    localparam logic [CODE_W-1:0] REL_C   = CODE_W'(RELEASE_CODE);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]        ROUNDS_C = 8'(ROUNDS);
    localparam logic [7:0]        MISS_C   = 8'(MAX_MISS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_REL = 3'd1,
        S_PLAY     = 3'd2,
        S_LOSS     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            cur, nxt;
    logic              armed, armed_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] goal_nxt;
    logic [7:0]        score_nxt, misses_nxt, round_nxt;
    logic [CNT_W-1:0]  react_nxt;
    logic              key_rel, key_hit, round_end, miss;
`ifdef TGC_BEST_TIME_EN
    logic [CNT_W-1:0]  best_nxt;
`endif

    assign state   = cur;
    assign key_rel = key_valid && (key_code == REL_C);
    assign key_hit = key_valid && (key_code != REL_C);

    always_comb begin
        nxt        = cur;
        armed_nxt  = armed;
        cnt_nxt    = cnt;
        goal_nxt   = goal_code;
        score_nxt  = score;
        misses_nxt = misses;
        round_nxt  = round_idx;
        react_nxt  = react_time;
        round_end  = 1'b0;
        miss       = 1'b0;
`ifdef TGC_BEST_TIME_EN
        best_nxt   = best_time;
`endif
        case (cur)
            S_IDLE, S_LOSS, S_DONE: begin
                if (key_rel) begin
                    score_nxt  = '0;
                    misses_nxt = '0;
                    round_nxt  = '0;
                    react_nxt  = '0;
                    armed_nxt  = 1'b1;
                    nxt        = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (key_rel) begin
                    armed_nxt = 1'b1;
                end else if (armed && !key_valid) begin
                    armed_nxt = 1'b0;
                    goal_nxt  = rand_code;
                    cnt_nxt   = '0;
                    nxt       = S_PLAY;
                end
            end
            S_PLAY: begin
                cnt_nxt = cnt + 1'b1;
                // A real keypress on the last counter cycle beats the timeout.
                if (key_hit) begin
                    round_end = 1'b1;
                    if (key_code == goal_code) begin
                        score_nxt = score + 8'd1;
                        react_nxt = cnt;
`ifdef TGC_BEST_TIME_EN
                        if (cnt < best_time) best_nxt = cnt;
`endif
                    end else begin
                        miss = 1'b1;
                    end
                end else if (cnt == TO_LAST) begin
                    round_end = 1'b1;
                    miss      = 1'b1;
                end
                if (round_end) begin
                    armed_nxt  = 1'b0;
                    round_nxt  = round_idx + 8'd1;
                    misses_nxt = misses + {7'd0, miss};
                    if (miss && (misses_nxt == MISS_C))
                        nxt = S_LOSS;
                    else if (round_nxt == ROUNDS_C)
                        nxt = S_DONE;
                    else
                        nxt = S_WAIT_REL;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= S_IDLE;
            armed      <= 1'b0;
            cnt        <= '0;
            goal_code  <= '0;
            score      <= '0;
            misses     <= '0;
            round_idx  <= '0;
            react_time <= '0;
            win        <= 1'b0;
            loss       <= 1'b0;
`ifdef TGC_BEST_TIME_EN
            best_time  <= '1;
`endif
        end else begin
            cur        <= nxt;
            armed      <= armed_nxt;
            cnt        <= cnt_nxt;
            goal_code  <= goal_nxt;
            score      <= score_nxt;
            misses     <= misses_nxt;
            round_idx  <= round_nxt;
            react_time <= react_nxt;
            win        <= (nxt == S_DONE);
            loss       <= (nxt == S_LOSS);
`ifdef TGC_BEST_TIME_EN
            best_time  <= best_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Bench for typing_game_ctrl: directed scenarios with literal expectations plus
// randomized play checked every cycle against a game-rule model.
module tb_typing_game_ctrl;

    localparam int CODE_W  = 5;
    localparam int REL     = 21;
    localparam int ROUNDS  = 2;
    localparam int MAXM    = 2;
    localparam int TO      = 16;
    localparam int CNT_W   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              key_valid = 1'b0;
    logic [CODE_W-1:0] key_code = '0;
    logic [CODE_W-1:0] rand_code = '0;
    logic [2:0]        state;
    logic [CODE_W-1:0] goal_code;
    logic [7:0]        score, misses, round_idx;
    logic [CNT_W-1:0]  react_time;
    logic              win, loss;
`ifdef TGC_BEST_TIME_EN
    logic [CNT_W-1:0]  best_time;
`endif

    typing_game_ctrl #(
        .CODE_W(CODE_W), .RELEASE_CODE(REL), .ROUNDS(ROUNDS),
        .MAX_MISS(MAXM), .TIMEOUT(TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .rand_code(rand_code), .state(state), .goal_code(goal_code),
        .score(score), .misses(misses), .round_idx(round_idx),
        .react_time(react_time), .win(win), .loss(loss)
`ifdef TGC_BEST_TIME_EN
        , .best_time(best_time)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Game model: phase 0 idle, 1 between rounds, 2 playing, 3 lost, 4 won.
    int m_phase, m_goal, m_score, m_miss, m_round, m_react, m_best, m_elapsed;
    bit m_released;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_phase = 0; m_goal = 0; m_score = 0; m_miss = 0; m_round = 0;
        m_react = 0; m_best = (1 << CNT_W) - 1; m_elapsed = 0; m_released = 0;
    endtask

    task automatic finish_round(input bit was_miss);
        m_round += 1;
        if (was_miss) m_miss += 1;
        m_released = 0;
        if (was_miss && m_miss == MAXM) m_phase = 3;
        else if (m_round == ROUNDS)     m_phase = 4;
        else                            m_phase = 1;
    endtask

    task automatic model_step(input bit r, input bit kv, input int kc, input int rc);
        bit is_rel;
        is_rel = kv && (kc == REL);
        if (r) begin
            model_reset();
            return;
        end
        if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
            if (is_rel) begin
                m_score = 0; m_miss = 0; m_round = 0; m_react = 0;
                m_released = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (is_rel) m_released = 1;
            else if (m_released && !kv) begin
                m_phase = 2; m_goal = rc; m_elapsed = 0;
            end
        end else begin
            if (kv && !is_rel) begin
                if (kc == m_goal) begin
                    m_score += 1;
                    m_react = m_elapsed;
                    if (m_elapsed < m_best) m_best = m_elapsed;
                    finish_round(0);
                end else begin
                    finish_round(1);
                end
            end else if (m_elapsed == TO - 1) begin
                finish_round(1);
            end else begin
                m_elapsed += 1;
            end
        end
    endtask

    // Called at a negedge: drive, let one rising edge happen, advance the model.
    task automatic tick(input bit r, input bit kv, input int kc, input int rc);
        rst = r; key_valid = kv; key_code = kc[CODE_W-1:0]; rand_code = rc[CODE_W-1:0];
        @(posedge clk);
        model_step(r, kv, kc, rc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_phase);
            chk("goal_code", int'(goal_code), m_goal);
            chk("score", int'(score), m_score);
            chk("misses", int'(misses), m_miss);
            chk("round_idx", int'(round_idx), m_round);
            chk("react_time", int'(react_time), m_react);
            chk("win", int'(win), int'(m_phase == 4));
            chk("loss", int'(loss), int'(m_phase == 3));
`ifdef TGC_BEST_TIME_EN
            chk("best_time", int'(best_time), m_best);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk_en = 1;
        tick(0, 0, 0, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'(score), 0);

        // Correct key on the fifth PLAY cycle.
        tick(0, 1, REL, 0);
        tick(0, 0, 0, 7);
        chk("play_goal", int'(goal_code), 7);
        idle(4);
        tick(0, 1, 7, 0);
        chk("react_score", int'(score), 1);
        chk("react_time4", int'(react_time), 4);
        chk("react_state", int'(state), 1);
        chk("model_react", m_react, 4);

        // Reset in mid-PLAY, with a release strobe in the same cycle.
        tick(0, 1, REL, 0);
        tick(0, 0, 0, 3);
        idle(2);
        tick(1, 1, REL, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_goal", int'(goal_code), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_loss", int'(loss), 0);

        // Two correct rounds win; later keys are ignored.
        tick(0, 1, REL, 0); tick(0, 0, 0, 7); tick(0, 1, 7, 0);
        tick(0, 1, REL, 0); tick(0, 0, 0, 5); tick(0, 1, 5, 0);
        chk("done_state", int'(state), 4);
        chk("done_win", int'(win), 1);
        chk("done_round", int'(round_idx), 2);
        tick(0, 1, 3, 0);
        chk("done_hold_state", int'(state), 4);
        chk("done_hold_score", int'(score), 2);

        // Two full timeouts lose.
        tick(0, 1, REL, 0); tick(0, 0, 0, 7); idle(16);
        chk("to1_misses", int'(misses), 1);
        chk("to1_state", int'(state), 1);
        tick(0, 1, REL, 0); tick(0, 0, 0, 7); idle(16);
        chk("to2_misses", int'(misses), 2);
        chk("to2_state", int'(state), 3);
        chk("to2_loss", int'(loss), 1);
        chk("model_loss", m_phase, 3);

        // Wrong key on the timeout cycle counts once.
        tick(0, 1, REL, 0); tick(0, 0, 0, 7); idle(15);
        tick(0, 1, 9, 0);
        chk("tie_misses", int'(misses), 1);
        chk("tie_round", int'(round_idx), 1);
        chk("tie_state", int'(state), 1);
        idle(1);
        chk("tie_misses_hold", int'(misses), 1);

        // Best time across games: 10, 4, then new game 6.
        tick(1, 0, 0, 0);
        tick(0, 1, REL, 0); tick(0, 0, 0, 7); idle(10); tick(0, 1, 7, 0);
        chk("bt_react10", int'(react_time), 10);
        tick(0, 1, REL, 0); tick(0, 0, 0, 1); idle(4); tick(0, 1, 1, 0);
        chk("bt_react4", int'(react_time), 4);
        chk("bt_done", int'(state), 4);
        tick(0, 1, REL, 0); tick(0, 0, 0, 2); idle(6); tick(0, 1, 2, 0);
        chk("bt_react6", int'(react_time), 6);
        chk("model_best", m_best, 4);
`ifdef TGC_BEST_TIME_EN
        chk("bt_best", int'(best_time), 4);
`endif

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            bit r, kv;
            int kc, rc, sel;
            r  = ($urandom_range(0, 299) == 0);
            kv = ($urandom_range(0, 3) == 0);
            rc = $urandom_range(0, 31);
            sel = $urandom_range(0, 2);
            if (sel == 0)      kc = REL;
            else if (sel == 1) kc = m_goal;
            else               kc = $urandom_range(0, 31);
            if (m_phase == 2 && m_elapsed == TO - 1 && kc == REL) kv = 0;
            tick(r, kv, kc, rc);
        end
        key_valid = 0;
        @(negedge clk);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
